// File: rtl/div_iterative_core_if.sv
// div_iterative_core_if: request/writeback bundle and shared types for the iterative divider
package div_pkg;
   localparam int XLEN  = 32;
   localparam int CLZ_W = $clog2(XLEN);
   localparam int ID_W  = 4;
   typedef logic [ID_W-1:0] id_t;
   typedef struct packed {
      logic remainder_op;
      logic negate_result;
      id_t  id;
   } div_attr_t;
   typedef struct packed {
      logic [XLEN-1:0]  unsigned_dividend;
      logic [XLEN-1:0]  unsigned_divisor;
      logic [CLZ_W-1:0] dividend_CLZ;
      logic [CLZ_W-1:0] divisor_CLZ;
      logic             divisor_is_zero;
      logic             reuse_result;
      div_attr_t        attr;
   } div_fifo_inputs_t;
endpackage

interface div_iterative_core_if;
   import div_pkg::*;
   logic             in_valid;
   logic             in_ready;
   div_fifo_inputs_t in_data;
   logic             wb_valid;
   logic             wb_ack;
   id_t              wb_id;
   logic [XLEN-1:0]  wb_data;
   modport master (output in_valid, in_data, wb_ack, input in_ready, wb_valid, wb_id, wb_data);
   modport slave  (input in_valid, in_data, wb_ack, output in_ready, wb_valid, wb_id, wb_data);
endinterface

// File: rtl/div_iterative_core.sv
// div_iterative_core: radix-2 shift/subtract unsigned divider iterating only over the significant bit span
module div_iterative_core
   import div_pkg::*;
(
   input logic                 clk,
   input logic                 rst,
   div_iterative_core_if.slave bus
);
   typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;
   state_t           state, state_n;
   div_attr_t        attr_r;
   logic [XLEN-1:0]  q_r, r_r, d_r, raw;
   logic [CLZ_W-1:0] count, shift;
   logic             accept, fast, ge;

   assign bus.in_ready = (state == IDLE) && !rst;
   assign accept       = bus.in_valid && bus.in_ready;
   assign fast         = bus.in_data.reuse_result || bus.in_data.divisor_is_zero ||
                         (bus.in_data.divisor_CLZ < bus.in_data.dividend_CLZ);
   assign shift        = bus.in_data.divisor_CLZ - bus.in_data.dividend_CLZ;
   assign ge           = r_r >= d_r;
   assign raw          = attr_r.remainder_op ? r_r : q_r;
   assign bus.wb_valid = state == DONE;
   assign bus.wb_id    = attr_r.id;
   assign bus.wb_data  = attr_r.negate_result ? ~raw + 1'b1 : raw;

   // state register; reset aborts any op in flight
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // next state: fast paths skip the loop, the loop ends after count reaches zero
   always_comb begin
      state_n = state;
      if (accept) state_n = fast ? DONE : DIVIDE;
      if (state == DIVIDE && count == '0) state_n = DONE;
      if (state == DONE && bus.wb_ack) state_n = IDLE;
   end

   // datapath: load operands on accept (reuse keeps q_r/r_r), then one restoring step per DIVIDE cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         q_r    <= '0;
         r_r    <= '0;
         d_r    <= '0;
         count  <= '0;
         attr_r <= '0;
      end else if (accept) begin
         attr_r <= bus.in_data.attr;
         if (!bus.in_data.reuse_result) begin
            q_r   <= bus.in_data.divisor_is_zero ? '1 : '0;
            r_r   <= bus.in_data.unsigned_dividend;
            d_r   <= bus.in_data.unsigned_divisor << shift;
            count <= shift;
         end
      end else if (state == DIVIDE) begin
         r_r   <= ge ? r_r - d_r : r_r;
         q_r   <= {q_r[XLEN-2:0], ge};
         d_r   <= d_r >> 1;
         count <= count - 1'b1;
      end
   end
endmodule
